// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a whole cyc,
// with a watchdog that turns a never-acknowledged stb into an error response.
module wb_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic [ADDR_W-1:0] wbm0_adr_i,
  input  logic [31:0]       wbm0_dat_i,
  input  logic              wbm0_we_i,
  input  logic [3:0]        wbm0_sel_i,
  input  logic              wbm0_stb_i,
  input  logic              wbm0_cyc_i,
  output logic [31:0]       wbm0_dat_o,
  output logic              wbm0_ack_o,
  output logic              wbm0_err_o,

  input  logic [ADDR_W-1:0] wbm1_adr_i,
  input  logic [31:0]       wbm1_dat_i,
  input  logic              wbm1_we_i,
  input  logic [3:0]        wbm1_sel_i,
  input  logic              wbm1_stb_i,
  input  logic              wbm1_cyc_i,
  output logic [31:0]       wbm1_dat_o,
  output logic              wbm1_ack_o,
  output logic              wbm1_err_o,

  output logic [ADDR_W-1:0] wbs_adr_o,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_we_o,
  output logic [3:0]        wbs_sel_o,
  output logic              wbs_stb_o,
  output logic              wbs_cyc_o,
  input  logic [31:0]       wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,

  output logic [1:0]        o_grant,
  output logic              o_timeout,
  output logic [7:0]        o_timeout_cnt
);

  // state | meaning
  // IDLE  | no master owns the bus
  // GNT0  | master 0 (host path) owns the bus until it drops cyc
  // GNT1  | master 1 (on-chip requester) owns the bus until it drops cyc
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  state_t      state_next;
  logic        last_gnt;
  logic        gnt0;
  logic        gnt1;
  logic        stb_req;
  logic        to_fire;
  logic [15:0] wd_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GNT0) begin
        last_gnt <= 1'b0;
      end else if (state_next == GNT1) begin
        last_gnt <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) begin
          state_next = last_gnt ? GNT0 : GNT1;
        end else if (wbm0_cyc_i) begin
          state_next = GNT0;
        end else if (wbm1_cyc_i) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!wbm0_cyc_i) begin
          state_next = wbm1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!wbm1_cyc_i) begin
          state_next = wbm0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = (state == GNT0);
    gnt1 = (state == GNT1);
  end

  assign o_grant = {gnt1, gnt0};

  // Request bundle of the owner; stb is also qualified by cyc so that a
  // master dropping cyc mid-access takes stb away from the slave at once.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_cyc_o = 1'b0;
    stb_req   = 1'b0;
    if (gnt0) begin
      wbs_adr_o = wbm0_adr_i;
      wbs_dat_o = wbm0_dat_i;
      wbs_we_o  = wbm0_we_i;
      wbs_sel_o = wbm0_sel_i;
      wbs_cyc_o = wbm0_cyc_i;
      stb_req   = wbm0_stb_i & wbm0_cyc_i;
    end else if (gnt1) begin
      wbs_adr_o = wbm1_adr_i;
      wbs_dat_o = wbm1_dat_i;
      wbs_we_o  = wbm1_we_i;
      wbs_sel_o = wbm1_sel_i;
      wbs_cyc_o = wbm1_cyc_i;
      stb_req   = wbm1_stb_i & wbm1_cyc_i;
    end
  end

  // A real ack/err in the expiry cycle wins over the watchdog.
  assign to_fire   = TO_EN && stb_req && !wbs_ack_i && !wbs_err_i && (wd_cnt == TO_LAST);
  assign wbs_stb_o = stb_req & ~to_fire;

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = gnt0 & wbs_ack_i;
  assign wbm1_ack_o = gnt1 & wbs_ack_i;
  assign wbm0_err_o = gnt0 & (wbs_err_i | to_fire);
  assign wbm1_err_o = gnt1 & (wbs_err_i | to_fire);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt <= '0;
    end else if (!wbs_stb_o || wbs_ack_i || wbs_err_i) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timeout     <= 1'b0;
      o_timeout_cnt <= '0;
    end else begin
      o_timeout <= to_fire;
      if (to_fire && (o_timeout_cnt != 8'hFF)) begin
        o_timeout_cnt <= o_timeout_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic, all checked
// cycle by cycle against an ownership/watchdog model of the arbiter.
module tb_wb_arbiter2;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic [31:0] s_dat;
  logic        s_ack, s_err;

  logic [31:0] m0_dat, m1_dat, wbs_adr, wbs_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        wbs_we, wbs_stb, wbs_cyc, o_timeout;
  logic [3:0]  wbs_sel;
  logic [1:0]  o_grant;
  logic [7:0]  o_timeout_cnt;

  logic [31:0] z_m0_dat, z_m1_dat, z_adr, z_dat;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
  logic        z_we, z_stb, z_cyc, z_timeout;
  logic [3:0]  z_sel;
  logic [1:0]  z_grant;
  logic [7:0]  z_timeout_cnt;

  wb_arbiter2 #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .wbm0_adr_i(adr[0]), .wbm0_dat_i(dat[0]), .wbm0_we_i(we[0]), .wbm0_sel_i(sel[0]),
    .wbm0_stb_i(stb[0]), .wbm0_cyc_i(cyc[0]),
    .wbm0_dat_o(m0_dat), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err),
    .wbm1_adr_i(adr[1]), .wbm1_dat_i(dat[1]), .wbm1_we_i(we[1]), .wbm1_sel_i(sel[1]),
    .wbm1_stb_i(stb[1]), .wbm1_cyc_i(cyc[1]),
    .wbm1_dat_o(m1_dat), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err),
    .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_dat), .wbs_we_o(wbs_we), .wbs_sel_o(wbs_sel),
    .wbs_stb_o(wbs_stb), .wbs_cyc_o(wbs_cyc),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .o_grant(o_grant), .o_timeout(o_timeout), .o_timeout_cnt(o_timeout_cnt)
  );

  wb_arbiter2 #(.ADDR_W(32), .TIMEOUT(0)) dut_nowd (
    .i_clk(clk), .i_rst_n(rst_n),
    .wbm0_adr_i(adr[0]), .wbm0_dat_i(dat[0]), .wbm0_we_i(we[0]), .wbm0_sel_i(sel[0]),
    .wbm0_stb_i(stb[0]), .wbm0_cyc_i(cyc[0]),
    .wbm0_dat_o(z_m0_dat), .wbm0_ack_o(z_m0_ack), .wbm0_err_o(z_m0_err),
    .wbm1_adr_i(adr[1]), .wbm1_dat_i(dat[1]), .wbm1_we_i(we[1]), .wbm1_sel_i(sel[1]),
    .wbm1_stb_i(stb[1]), .wbm1_cyc_i(cyc[1]),
    .wbm1_dat_o(z_m1_dat), .wbm1_ack_o(z_m1_ack), .wbm1_err_o(z_m1_err),
    .wbs_adr_o(z_adr), .wbs_dat_o(z_dat), .wbs_we_o(z_we), .wbs_sel_o(z_sel),
    .wbs_stb_o(z_stb), .wbs_cyc_o(z_cyc),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .o_grant(z_grant), .o_timeout(z_timeout), .o_timeout_cnt(z_timeout_cnt)
  );

  // Model: owner = -1 (nobody) or master index; wd = consecutive unanswered stb cycles.
  int owner, last, wd, tcnt;
  bit tpulse;
  int passes, total;
  int ack0_seen, ack1_seen, err0_seen;

  task automatic model_reset();
    owner = -1; last = 1; wd = 0; tcnt = 0; tpulse = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    bit          rs, fire, ecyc;
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    logic        ew;
    logic [3:0]  es;
    @(negedge clk);
    rs = 0; ecyc = 0; ea = '0; ed = '0; ew = 1'b0; es = '0; eg = 2'b00;
    if (owner >= 0) begin
      eg   = (owner == 0) ? 2'b01 : 2'b10;
      ecyc = cyc[owner];
      rs   = cyc[owner] && stb[owner];
      ea   = adr[owner]; ed = dat[owner]; ew = we[owner]; es = sel[owner];
    end
    fire = rs && !s_ack && !s_err && (wd == TO - 1);
    chk("grant", o_grant, eg);
    chk("wbs_adr", wbs_adr, ea);
    chk("wbs_dat", wbs_dat, ed);
    chk("wbs_we", wbs_we, ew);
    chk("wbs_sel", wbs_sel, es);
    chk("wbs_cyc", wbs_cyc, ecyc);
    chk("wbs_stb", wbs_stb, rs && !fire);
    chk("m0_ack", m0_ack, owner == 0 && s_ack);
    chk("m1_ack", m1_ack, owner == 1 && s_ack);
    chk("m0_err", m0_err, owner == 0 && (s_err || fire));
    chk("m1_err", m1_err, owner == 1 && (s_err || fire));
    chk("m0_dat", m0_dat, s_dat);
    chk("m1_dat", m1_dat, s_dat);
    chk("timeout", o_timeout, tpulse);
    chk("timeout_cnt", o_timeout_cnt, tcnt);
    chk("nowd_grant", z_grant, eg);
    chk("nowd_bus", {z_adr, z_dat}, {ea, ed});
    chk("nowd_ctl", {z_we, z_sel, z_cyc, z_stb}, {ew, es, ecyc, rs});
    chk("nowd_rsp", {z_m0_ack, z_m1_ack, z_m0_err, z_m1_err},
        {owner == 0 && s_ack, owner == 1 && s_ack, owner == 0 && s_err, owner == 1 && s_err});
    chk("nowd_dat", {z_m0_dat, z_m1_dat}, {s_dat, s_dat});
    chk("nowd_timeout", {z_timeout, z_timeout_cnt}, 9'd0);
    ack0_seen += int'(m0_ack);
    ack1_seen += int'(m1_ack);
    err0_seen += int'(m0_err);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      wd     = (rs && !fire && !s_ack && !s_err) ? wd + 1 : 0;
      tpulse = fire;
      if (fire && tcnt < 255) tcnt++;
      if (owner < 0) begin
        if (cyc[0] && cyc[1]) owner = 1 - last;
        else if (cyc[0]) owner = 0;
        else if (cyc[1]) owner = 1;
      end else if (!cyc[owner]) begin
        owner = cyc[1 - owner] ? 1 - owner : -1;
      end
      if (owner >= 0) last = owner;
    end
    #1;
  endtask

  task automatic idle_masters();
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0; s_err = 1'b0;
  endtask

  initial begin
    int ack_pct;
    passes = 0; total = 0; ack0_seen = 0; ack1_seen = 0; err0_seen = 0;
    rst_n = 1'b0; idle_masters(); we = 2'b00; s_dat = '0;
    for (int m = 0; m < 2; m++) begin adr[m] = '0; dat[m] = '0; sel[m] = '0; end
    model_reset();
    #1;
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_outs", {wbs_cyc, wbs_stb, m0_ack, m0_err, m1_ack, m1_err, o_timeout}, 7'd0);
    chk("rst_cnt", o_timeout_cnt, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single master 0 write, slave acks two cycles after stb
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h10; dat[0] = 32'h12; sel[0] = 4'hF;
    ack0_seen = 0; ack1_seen = 0;
    tick();
    chk("t1_grant", o_grant, 2'b01);
    chk("t1_adr", wbs_adr, 32'h10);
    tick(); tick();
    s_ack = 1; s_dat = $urandom;
    tick();
    idle_masters();
    tick();
    chk("t1_ack_pulses", ack0_seen, 1);
    chk("t1_m1_ack", ack1_seen, 0);

    // Tie-break straight out of reset, handover, and repeat tie
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1; cyc = 2'b11;
    tick();
    chk("t2_tie_first", o_grant, 2'b01);
    cyc[0] = 0;
    tick();
    chk("t2_handover", o_grant, 2'b10);
    cyc[1] = 0;
    tick();
    chk("t2_release", o_grant, 2'b00);
    cyc = 2'b11;
    tick();
    chk("t2_tie_again", o_grant, 2'b01);
    idle_masters();
    tick();

    // Locked 4-beat read by master 1 while master 0 keeps requesting
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h0F; sel[1] = 4'hF;
    tick();
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      adr[1] = 32'h0F + 32'(i); s_ack = 1; s_dat = $urandom;
      chk("t3_locked", o_grant, 2'b10);
      tick();
    end
    s_ack = 0; cyc[1] = 0; stb[1] = 0;
    tick();
    chk("t3_after", o_grant, 2'b01);
    s_ack = 1;
    tick();
    idle_masters();
    tick();

    // Watchdog: slave never answers
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'hDEAD_0000;
    tick();
    err0_seen = 0;
    repeat (TO - 1) tick();
    chk("t4_no_early_err", err0_seen, 0);
    tick();
    chk("t4_err_on_last", err0_seen, 1);
    chk("t4_pulse", o_timeout, 1'b1);
    chk("t4_cnt", o_timeout_cnt, 8'd1);
    idle_masters();
    tick();

    // Slave acks in exactly the cycle the watchdog would expire
    cyc[0] = 1; stb[0] = 1;
    tick();
    err0_seen = 0; ack0_seen = 0;
    repeat (TO - 1) tick();
    s_ack = 1;
    tick();
    idle_masters();
    tick();
    chk("t5_no_err", err0_seen, 0);
    chk("t5_ack", ack0_seen, 1);
    chk("t5_no_pulse", o_timeout, 1'b0);
    chk("t5_cnt_same", o_timeout_cnt, 8'd1);

    // 300 further expiries saturate the counter
    cyc[0] = 1; stb[0] = 1;
    tick();
    repeat (300 * TO) tick();
    chk("t4_saturate", o_timeout_cnt, 8'd255);

    // Reset in the middle of a granted access
    s_ack = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant", o_grant, 2'b00);
    chk("t6_outs", {wbs_cyc, wbs_stb, m0_ack, m0_err, m1_ack, m1_err, o_timeout}, 7'd0);
    chk("t6_cnt", o_timeout_cnt, 8'd0);
    model_reset();
    s_ack = 0;
    tick();
    rst_n = 1'b1; cyc = 2'b11; stb = 2'b11;
    tick();
    chk("t6_fresh_tie", o_grant, 2'b01);
    idle_masters();
    tick();

    // Random traffic against the model
    ack_pct = 20;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) ack_pct = int'($urandom_range(0, 40));
      for (int m = 0; m < 2; m++) begin
        if (cyc[m] && ($urandom % 8 == 0)) cyc[m] = 0;
        else if (!cyc[m] && ($urandom % 4 == 0)) cyc[m] = 1;
        stb[m] = cyc[m] && ($urandom % 5 != 0);
        adr[m] = $urandom; dat[m] = $urandom; we[m] = 1'($urandom); sel[m] = 4'($urandom);
      end
      s_ack = (int'($urandom_range(0, 99)) < ack_pct);
      s_err = ($urandom % 20 == 0);
      s_dat = $urandom;
      tick();
    end
    idle_masters();
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone classic arbiter placed between the bus masters and `wishbone_mux`. Master 0 is the host path (`axis_wb_master`). Master 1 is an on-chip requester, such as a periodic PWM-decoder poller. The block grants the shared bus round-robin and holds the grant for a whole `cyc` cycle, including locked multi-beat sequences. A watchdog terminates any slave access that never acknowledges, so an unmapped address cannot hang the host link.

## Interface
Parameters:
- `ADDR_W`, default 32: Wishbone address width.
- `TIMEOUT`, default 255: cycles of unacknowledged `stb` before a forced error. Legal range 1..65535. A value of 0 disables the watchdog.

Ports:
- `i_clk` in, 1: single clock. All logic is rising-edge.
- `i_rst_n` in, 1: reset, asynchronous assert, active-low. Release is synchronous to `i_clk` upstream.
- `wbm0_adr_i[ADDR_W]`, `wbm0_dat_i[32]`, `wbm0_we_i`, `wbm0_sel_i[4]`, `wbm0_stb_i`, `wbm0_cyc_i` in: master 0 request bundle.
- `wbm0_dat_o[32]`, `wbm0_ack_o`, `wbm0_err_o` out: master 0 response bundle.
- `wbm1_*` in/out: master 1, identical to the master 0 bundle.
- `wbs_adr_o[ADDR_W]`, `wbs_dat_o[32]`, `wbs_we_o`, `wbs_sel_o[4]`, `wbs_stb_o`, `wbs_cyc_o` out: to the slave or mux.
- `wbs_dat_i[32]`, `wbs_ack_i`, `wbs_err_i` in: from the slave or mux.
- `o_grant` out, 2: one-hot registered grant. `2'b00` means idle.
- `o_timeout` out, 1: one-cycle pulse on each watchdog expiry.
- `o_timeout_cnt` out, 8: saturating count of watchdog expiries.

## Operation
- States: `IDLE`, `GNT0`, `GNT1`. `o_grant` reflects the state: `00`, `01`, `10`.
- **`IDLE`**: on a clock edge with any `wbmN_cyc_i` high, move to that master's grant state.
  - If both are requesting, grant the master that was not granted last.
  - The last-granted pointer resets to 1, so master 0 wins the first tie.
- **`GNTn`**: held while `wbmn_cyc_i` is high, regardless of the other master.
  - When `wbmn_cyc_i` is sampled low and the other master's `cyc` is high, go directly to the other grant state.
  - Otherwise, go to `IDLE`.
  - The pointer updates to n on entry.
- **Slave mux**: combinational from the grant register.
  - `wbs_{adr,dat,we,sel}_o` follow the granted master, and are 0 in `IDLE`.
  - `wbs_cyc_o = cyc_n & grant_n`.
  - `wbs_stb_o = stb_n & grant_n & ~to_fire`.
- **Responses**:
  - `wbs_dat_i` is broadcast to both `wbmN_dat_o`.
  - `ack`/`err` go only to the granted master. A non-granted master sees `ack = err = 0`, always.
- **Watchdog**:
  - A 16-bit counter clears whenever `wbs_stb_o` is low, or `wbs_ack_i` or `wbs_err_i` is high. It increments otherwise.
  - `to_fire` is the combinational condition `cnt == TIMEOUT - 1` with `stb` high and no `ack`/`err` present.
  - When `to_fire` is true:
    - the granted master receives `err_o = 1` for that cycle;
    - slave `stb` is masked;
    - the counter clears.
  - `o_timeout` is registered: it pulses on the cycle after `to_fire`.
  - `o_timeout_cnt` increments the same cycle `o_timeout` rises and saturates at 255.
- A slave `err` passes through unchanged and does not count as a timeout.

## Timing
- **Reset values**: while `i_rst_n` = 0, asynchronously, all of the following are 0:
  - `o_grant` = 0, state = `IDLE`;
  - `o_timeout` = 0, `o_timeout_cnt` = 0, watchdog counter = 0;
  - all `ack`/`err`/`stb`/`cyc` outputs.
- **Grant latency**: `cyc` asserted at edge k from `IDLE` gives `o_grant` valid after edge k+1, and `wbs_cyc_o` visible in that cycle.
- **Data path**: the `ack` path is combinational, with zero added latency per beat once granted.
- **Handover**: the granted master drops `cyc` at edge k while the other master is waiting. The new grant is valid after edge k+1, with no idle cycle.
- **Release**: `cyc` low while the other master is idle returns to `IDLE` at the next edge.
- **Simultaneous requests**: both `cyc` rise on the same edge. Resolved by the pointer only.
- **Same-cycle `ack` and `to_fire`**: `ack` wins. There is no `err` and no count.
- **Mid-access**: a `cyc` drop mid-access abandons the access. The slave sees `cyc`/`stb` low on the same cycle.
- **Reset mid-transfer**: all outputs drop immediately and the pointer returns to 1.
- **`TIMEOUT` = 0**: `to_fire` is never asserted, and `o_timeout_cnt` stays 0.

## Test plan
1. **Single master 0 write.** Master 0 writes `0x12` to `0x10`; the slave acks 2 cycles after `stb`.
   - `o_grant` = `01` one cycle after `cyc`.
   - `wbs_adr_o` = `0x10`.
   - `wbm0_ack_o` pulses once.
   - `wbm1_ack_o` stays 0.
2. **Tie-break out of reset.** Both `cyc` rise on the first edge after reset.
   - Master 0 is granted first.
   - Master 0 drops `cyc`; master 1 is granted after exactly 1 edge.
   - Repeat the tie; master 0 wins again, because the pointer is now 1.
3. **Locked sequence.** Master 1 holds `cyc` for a 4-beat read of `0x0F..0x12` while master 0 requests continuously.
   - The grant stays `10` for all 4 acks.
   - Master 0 is granted only after master 1 drops `cyc`.
4. **Watchdog, `TIMEOUT` = 8.** The slave never acks.
   - The granted master sees `err` on the 8th `stb` cycle.
   - `o_timeout` pulses on the following cycle.
   - `o_timeout_cnt` = 1.
   - Repeat 300 times; `o_timeout_cnt` saturates at 255.
5. **Boundary `ack` vs watchdog.** The slave acks exactly on the `to_fire` cycle.
   - `ack` is delivered.
   - No `err`, no `o_timeout`.
   - Count is unchanged.
6. **Reset mid-transfer.** Assert `i_rst_n` = 0 during a granted `stb`.
   - All outputs go to 0 asynchronously.
   - After release, a fresh tie is granted to master 0.
